// File: rtl/bsg_axi_mem_responder.sv
// AXI4 slave memory serving one INCR burst at a time from a beat-wide word array.
// Optional: define BSG_AXI_MEM_RESPONDER_LATENCY_EN to insert read_latency_p idle cycles before B and the first R.
module bsg_axi_mem_responder #(
    parameter int axi_id_width_p    = 6,
    parameter int axi_addr_width_p  = 64,
    parameter int axi_data_width_p  = 512,
    parameter int mem_els_p         = 4096,
    parameter int read_latency_p    = 0,
    localparam int axi_strb_width_lp = axi_data_width_p >> 3
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [axi_id_width_p-1:0]     axi_awid_i,
    input  logic [axi_addr_width_p-1:0]   axi_awaddr_i,
    input  logic [7:0]                    axi_awlen_i,
    input  logic [2:0]                    axi_awsize_i,
    input  logic [1:0]                    axi_awburst_i,
    input  logic [3:0]                    axi_awcache_i,
    input  logic [2:0]                    axi_awprot_i,
    input  logic                          axi_awlock_i,
    input  logic                          axi_awvalid_i,
    output logic                          axi_awready_o,
    input  logic [axi_data_width_p-1:0]   axi_wdata_i,
    input  logic [axi_strb_width_lp-1:0]  axi_wstrb_i,
    input  logic                          axi_wlast_i,
    input  logic                          axi_wvalid_i,
    output logic                          axi_wready_o,
    output logic [axi_id_width_p-1:0]     axi_bid_o,
    output logic [1:0]                    axi_bresp_o,
    output logic                          axi_bvalid_o,
    input  logic                          axi_bready_i,
    input  logic [axi_id_width_p-1:0]     axi_arid_i,
    input  logic [axi_addr_width_p-1:0]   axi_araddr_i,
    input  logic [7:0]                    axi_arlen_i,
    input  logic [2:0]                    axi_arsize_i,
    input  logic [1:0]                    axi_arburst_i,
    input  logic [3:0]                    axi_arcache_i,
    input  logic [2:0]                    axi_arprot_i,
    input  logic                          axi_arlock_i,
    input  logic                          axi_arvalid_i,
    output logic                          axi_arready_o,
    output logic [axi_id_width_p-1:0]     axi_rid_o,
    output logic [axi_data_width_p-1:0]   axi_rdata_o,
    output logic [1:0]                    axi_rresp_o,
    output logic                          axi_rlast_o,
    output logic                          axi_rvalid_o,
    input  logic                          axi_rready_i
);
    localparam int strb_lg_lp = $clog2(axi_strb_width_lp);
    localparam int idx_w_lp   = $clog2(mem_els_p);
    localparam logic [idx_w_lp-1:0] idx_one_lp = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WDATA, S_WRESP, S_RISSUE, S_RDATA
`ifdef BSG_AXI_MEM_RESPONDER_LATENCY_EN
        , S_WAIT
`endif
    } state_e;

    state_e                      state_q, state_d;
    logic                        prio_rd_q, prio_rd_d;
    logic [axi_id_width_p-1:0]   id_q, id_d;
    logic [idx_w_lp-1:0]         idx_q, idx_d;
    logic [7:0]                  len_q, len_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic                        err_q, err_d;
    logic [axi_data_width_p-1:0] rdata_q;
    logic [axi_data_width_p-1:0] mem_q [mem_els_p];
    logic                        awready, arready, wready, bvalid, rvalid;
    logic                        last_beat;
`ifdef BSG_AXI_MEM_RESPONDER_LATENCY_EN
    logic [7:0]                  lat_q, lat_d;
    logic                        wait_rd_q, wait_rd_d;
`endif

    assign last_beat = (cnt_q == len_q);

    always_comb begin
        state_d   = state_q;
        prio_rd_d = prio_rd_q;
        id_d      = id_q;
        idx_d     = idx_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        awready   = 1'b0;
        arready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        rvalid    = 1'b0;
`ifdef BSG_AXI_MEM_RESPONDER_LATENCY_EN
        lat_d     = lat_q;
        wait_rd_d = wait_rd_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Readies are gated by reset so they stay low while reset is held.
                if (reset_n_i) begin
                    awready = axi_awvalid_i && (!axi_arvalid_i || !prio_rd_q);
                    arready = axi_arvalid_i && (!axi_awvalid_i || prio_rd_q);
                end
                if (arready) begin
                    id_d      = axi_arid_i;
                    idx_d     = axi_araddr_i[strb_lg_lp +: idx_w_lp];
                    len_d     = axi_arlen_i;
                    cnt_d     = 8'd0;
                    err_d     = (axi_arburst_i != 2'b01) || (axi_arsize_i != 3'(strb_lg_lp));
                    prio_rd_d = 1'b0;
                    state_d   = S_RISSUE;
`ifdef BSG_AXI_MEM_RESPONDER_LATENCY_EN
                    if (read_latency_p != 0) begin
                        state_d   = S_WAIT;
                        lat_d     = 8'(read_latency_p);
                        wait_rd_d = 1'b1;
                    end
`endif
                end else if (awready) begin
                    id_d      = axi_awid_i;
                    idx_d     = axi_awaddr_i[strb_lg_lp +: idx_w_lp];
                    len_d     = axi_awlen_i;
                    cnt_d     = 8'd0;
                    err_d     = (axi_awburst_i != 2'b01) || (axi_awsize_i != 3'(strb_lg_lp));
                    prio_rd_d = 1'b1;
                    state_d   = S_WDATA;
                end
            end
            S_WDATA: begin
                wready = 1'b1;
                if (axi_wvalid_i) begin
                    idx_d = idx_q + idx_one_lp;
                    if (axi_wlast_i != last_beat) err_d = 1'b1;
                    if (last_beat) begin
                        state_d = S_WRESP;
`ifdef BSG_AXI_MEM_RESPONDER_LATENCY_EN
                        if (read_latency_p != 0) begin
                            state_d   = S_WAIT;
                            lat_d     = 8'(read_latency_p);
                            wait_rd_d = 1'b0;
                        end
`endif
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_WRESP: begin
                bvalid = 1'b1;
                if (axi_bready_i) state_d = S_IDLE;
            end
            S_RISSUE: state_d = S_RDATA;
            S_RDATA: begin
                rvalid = 1'b1;
                if (axi_rready_i) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + idx_one_lp;
                        cnt_d   = cnt_q + 8'd1;
                        state_d = S_RISSUE;
                    end
                end
            end
`ifdef BSG_AXI_MEM_RESPONDER_LATENCY_EN
            S_WAIT: begin
                lat_d = lat_q - 8'd1;
                if (lat_q <= 8'd1) state_d = wait_rd_q ? S_RISSUE : S_WRESP;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            prio_rd_q <= 1'b1;
            id_q      <= '0;
            idx_q     <= '0;
            len_q     <= 8'd0;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
`ifdef BSG_AXI_MEM_RESPONDER_LATENCY_EN
            lat_q     <= 8'd0;
            wait_rd_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            prio_rd_q <= prio_rd_d;
            id_q      <= id_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`ifdef BSG_AXI_MEM_RESPONDER_LATENCY_EN
            lat_q     <= lat_d;
            wait_rd_q <= wait_rd_d;
`endif
        end
    end

    // Array has no reset so it maps onto block RAM; contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (state_q == S_WDATA && axi_wvalid_i && !err_q) begin
            for (int b = 0; b < axi_strb_width_lp; b++) begin
                if (axi_wstrb_i[b]) mem_q[idx_q][b*8 +: 8] <= axi_wdata_i[b*8 +: 8];
            end
        end
        if (state_q == S_RISSUE) rdata_q <= mem_q[idx_q];
    end

    assign axi_awready_o = awready;
    assign axi_arready_o = arready;
    assign axi_wready_o  = wready;
    assign axi_bvalid_o  = bvalid;
    assign axi_bid_o     = bvalid ? id_q : '0;
    assign axi_bresp_o   = (bvalid && err_q) ? 2'b10 : 2'b00;
    assign axi_rvalid_o  = rvalid;
    assign axi_rid_o     = rvalid ? id_q : '0;
    assign axi_rdata_o   = (rvalid && !err_q) ? rdata_q : '0;
    assign axi_rresp_o   = (rvalid && err_q) ? 2'b10 : 2'b00;
    assign axi_rlast_o   = rvalid && last_beat;

    logic unused_inputs;
    assign unused_inputs = ^{axi_awcache_i, axi_awprot_i, axi_awlock_i, axi_awaddr_i,
                             axi_arcache_i, axi_arprot_i, axi_arlock_i, axi_araddr_i};
`ifndef BSG_AXI_MEM_RESPONDER_LATENCY_EN
    logic [7:0] unused_latency;
    assign unused_latency = 8'(read_latency_p);
`endif
endmodule

// File: doc/bsg_axi_mem_responder.md
Name: bsg_axi_mem_responder

Overview:
- Synthesizable AXI4 slave memory that answers the burst traffic produced by the manycore cache-to-AXI path.
- Stands in for DDR/shell memory in simulation and in small FPGA builds.
- Accepts one transaction at a time (INCR bursts only) into an internal word array.
- Returns read beats and write responses echoing the request ID.

Parameters:
- axi_id_width_p, 6, AXI ID width.
- axi_addr_width_p, 64, AXI byte address width.
- axi_data_width_p, 512, data beat width in bits (power of two, >= 32).
- mem_els_p, 4096, number of beat-wide words in the array (power of two).
- read_latency_p, 0, extra idle cycles before first R beat and before B (used only with the optional feature).
- axi_strb_width_lp, axi_data_width_p>>3, derived strobe width.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset
- axi_awid_i / awaddr_i / awlen_i / awsize_i / awburst_i  in  id/addr/8/3/2  write address fields
- axi_awcache_i / awprot_i / awlock_i  in  4/3/1  accepted, ignored
- axi_awvalid_i  in  1;  axi_awready_o  out  1
- axi_wdata_i / wstrb_i / wlast_i / wvalid_i  in  data/strb/1/1;  axi_wready_o  out  1
- axi_bid_o / bresp_o / bvalid_o  out  id/2/1;  axi_bready_i  in  1
- axi_arid_i / araddr_i / arlen_i / arsize_i / arburst_i  in  id/addr/8/3/2  read address fields
- axi_arcache_i / arprot_i / arlock_i  in  4/3/1  ignored
- axi_arvalid_i  in  1;  axi_arready_o  out  1
- axi_rid_o / rdata_o / rresp_o / rlast_o / rvalid_o  out  id/data/2/1/1;  axi_rready_i  in  1

Behaviour:
- Reset is asynchronous and active-low on reset_n_i, single clock clk_i.
- During reset: every valid/ready output is 0, bresp/rresp/rdata/rlast/ids are 0, FSM is IDLE, priority flag favours read. Array contents are not reset.
- FSM states: IDLE, WDATA, WRESP, RISSUE, RDATA (plus WAIT with the optional feature).
- IDLE, arbitration:
  - Only awvalid: awready=1.
  - Only arvalid: arready=1.
  - Both valid: grant the side not served last; the priority flag toggles on every grant.
  - awready and arready are never both 1 in the same cycle.
- Grant latches id, start index, len and error flag. Start index = addr[log2(strb)+:log2(mem_els_p)], i.e. the address wraps modulo the array size.
- Error flag is set when burst!=2'b01 (INCR) or size!=log2(axi_strb_width_lp).
- AW handshake -> WDATA:
  - wready=1 in WDATA; each W handshake writes the strobed bytes at the current index, then index++ (wraps at mem_els_p), beat count++.
  - Writes are suppressed when the error flag is set.
  - Exit after awlen+1 beats -> WRESP. A wlast value that disagrees with the beat position sets the error flag; remaining beats are still consumed by count.
- WRESP: bvalid=1 with latched id; bresp=2'b10 if error else 2'b00. On bready -> IDLE.
- AR handshake -> RISSUE: array is read synchronously (data valid next cycle) -> RDATA.
- RDATA:
  - rvalid=1, rid=latched id, rdata=read word (zero if error), rresp=error?2'b10:2'b00, rlast=1 on beat arlen.
  - rdata and all R outputs stay stable while rready=0.
  - On handshake: last beat -> IDLE; otherwise index++ -> RISSUE.
  - Throughput is one beat per 2 cycles.
- awlen/arlen=0: single beat; rlast and exit on the first beat.
- awlen=255: 256 beats; the counter is 8 bits and must not wrap early.
- Write then read of the same address: the read returns the new data (transactions are serialized).
- AXI rules: valid is never withdrawn before handshake; ready outputs never depend combinationally on ready inputs.
- Reset mid-burst: all outputs drop to reset values immediately; the partial burst is abandoned and the array keeps the beats already written.

Optional Feature:
- Macro BSG_AXI_MEM_RESPONDER_LATENCY_EN.
- Defined: a WAIT state and an 8-bit down-counter loaded with read_latency_p are inserted between WDATA and WRESP, and between the AR grant and the first RISSUE. Outputs stay idle while counting. read_latency_p=0 behaves identically to the undefined build.
- Undefined: no WAIT state, no counter logic, read_latency_p is ignored.

Test Plan:
- Reset released; AW id=3, addr=0x40, len=3, size=6, INCR; four W beats with full strobes, data 0xA..0xD -> B id=3, resp=00 after the fourth beat; AR same addr/len -> four R beats 0xA..0xD, id=3, rlast on beat 4 only.
- Write addr=0x0, len=0, wstrb=0x0F data all-ones over a prior zero word -> read returns only bytes 0..3 = 0xFF, rest 0x00.
- awvalid and arvalid asserted together three times -> grants alternate read, write, read; awready and arready never both high.
- rready held low 5 cycles on beat 2 of a len=7 read -> rdata/rid/rlast stable and rvalid stays high; 8 beats total, in order.
- AR with arburst=2'b10 (WRAP), len=1 -> two beats rresp=10, rdata=0; AW with awsize=2 -> writes suppressed, bresp=10; wlast early on beat 1 of len=2 -> 3 beats consumed, bresp=10.
- reset_n_i pulsed low during beat 2 of a len=7 write -> all valids/readies 0 asynchronously; after release a new len=0 write/read completes correctly; with BSG_AXI_MEM_RESPONDER_LATENCY_EN and read_latency_p=4, first rvalid appears exactly 4 cycles later than in the baseline build.
